// File: rtl/irq_pending_latch8.sv
// Request-capture stage: synchronises eight async request lines, latches their
// rising edges as pending events and offers the highest enabled one over valid/ready.
module irq_pending_latch8 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_in,
   input  logic [7:0] mask,
   input  logic       clr_all,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [2:0] out_id,
   output logic [7:0] pending,
   output logic [7:0] overrun
);

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0]                  req_d_q;
   logic [7:0]                  sync;
   logic [7:0]                  rise;
   logic [7:0]                  ack_mask;
   logic [7:0]                  offerable;
   logic [7:0]                  pending_q, pending_d;
   logic [7:0]                  overrun_q, overrun_d;
   state_t                      state_q, state_d;
   logic                        out_valid_q, out_valid_d;
   logic [2:0]                  out_id_q, out_id_d;

   // Bit 7 wins, matching the downstream 8-to-3 encoder.
   function automatic logic [2:0] prio_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         req_d_q <= '0;
      end else begin
         sync_q[0] <= req_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         req_d_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync      = sync_q[SYNC_STAGES-1];
   assign rise      = sync & ~req_d_q;
   assign ack_mask  = (out_valid_q && out_ready) ? 8'(8'd1 << out_id_q) : 8'd0;
   assign offerable = pending_q & mask;

   // A rise on the bit being acked re-arms it rather than counting as lost.
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      if (clr_all) begin
         pending_d = '0;
         overrun_d = '0;
      end else begin
         pending_d = (pending_q & ~ack_mask) | rise;
         overrun_d = overrun_q | (rise & pending_q & ~ack_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_id_q    <= 3'd0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
      end
   end

   // clr_all also suppresses a new offer, since the pending bits are being wiped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!clr_all && (offerable != 8'd0)) state_d = OFFER;
         OFFER:   if (clr_all || out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid_d = (state_d == OFFER);
      out_id_d    = out_id_q;
      if (state_q == IDLE && state_d == OFFER) out_id_d = prio_idx(offerable);
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign pending   = pending_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_irq_pending_latch8.sv
// Directed bench for irq_pending_latch8: capture latency, priority, offer hold,
// masking, overrun/clear and asynchronous reset behaviour.
module tb_irq_pending_latch8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req_in;
   logic [7:0] mask;
   logic       clr_all;
   logic       out_ready;
   logic       out_valid;
   logic [2:0] out_id;
   logic [7:0] pending;
   logic [7:0] overrun;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   irq_pending_latch8 #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .mask      (mask),
      .clr_all   (clr_all),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_id    (out_id),
      .pending   (pending),
      .overrun   (overrun)
   );

   // Inputs change and outputs are sampled on the falling edge; each call passes one rising edge.
   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_in = '0; mask = 8'hFF; clr_all = 1'b0; out_ready = 1'b0;
      #2;
      checks++;
      if ({out_valid, out_id, pending, overrun} !== 20'd0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b id=%0d pending=%h overrun=%h, want all 0",
                  out_valid, out_id, pending, overrun);
      end
      step(2);
      rst_n = 1'b1;
      step(4);
      checks++;
      if ({out_valid, pending} !== 9'd0) begin
         errors++;
         $display("FAIL reset_idle: got valid=%b pending=%h, want 0/00", out_valid, pending);
      end
   endtask

   task automatic test_single_event();
      mask = 8'hFF; out_ready = 1'b1;
      req_in = 8'h01; step();          // edge N
      req_in = 8'h00; step(2);         // N+2
      checks++;
      if (pending !== 8'h01 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pending: got pending=%h valid=%b, want 01/0", pending, out_valid);
      end
      step();                          // N+3
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd0) begin
         errors++;
         $display("FAIL single_offer: got valid=%b id=%0d, want 1/0", out_valid, out_id);
      end
      step();                          // N+4
      checks++;
      if (pending !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_ack: got pending=%h valid=%b, want 00/0", pending, out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_priority_hold();
      req_in = 8'h05; step();
      req_in = 8'h00; step(3);
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd2 || pending !== 8'h05) begin
         errors++;
         $display("FAIL prio_offer: got valid=%b id=%0d pending=%h, want 1/2/05", out_valid, out_id, pending);
      end
      step(2);
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd2) begin
         errors++;
         $display("FAIL prio_hold: got valid=%b id=%0d, want 1/2", out_valid, out_id);
      end
      out_ready = 1'b1; step();        // accept edge M
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || pending !== 8'h01) begin
         errors++;
         $display("FAIL prio_bubble: got valid=%b pending=%h, want 0/01", out_valid, pending);
      end
      step();                          // M+1
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd0) begin
         errors++;
         $display("FAIL prio_next: got valid=%b id=%0d, want 1/0", out_valid, out_id);
      end
      out_ready = 1'b1; step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || pending !== 8'h00) begin
         errors++;
         $display("FAIL prio_drain: got valid=%b pending=%h, want 0/00", out_valid, pending);
      end
   endtask

   task automatic test_offer_stability();
      req_in = 8'h02; step();
      req_in = 8'h00; step(3);
      req_in = 8'h40; step();
      req_in = 8'h00; step(2);
      checks++;
      if (pending !== 8'h42 || out_valid !== 1'b1 || out_id !== 3'd1) begin
         errors++;
         $display("FAIL stable_hold: got pending=%h valid=%b id=%0d, want 42/1/1", pending, out_valid, out_id);
      end
      step(2);
      checks++;
      if (out_id !== 3'd1) begin
         errors++;
         $display("FAIL stable_hold2: got id=%0d, want 1", out_id);
      end
      out_ready = 1'b1; step();
      out_ready = 1'b0;
      checks++;
      if (pending !== 8'h40 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stable_ack: got pending=%h valid=%b, want 40/0", pending, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd6) begin
         errors++;
         $display("FAIL stable_next: got valid=%b id=%0d, want 1/6", out_valid, out_id);
      end
      out_ready = 1'b1; step();
      out_ready = 1'b0;
   endtask

   task automatic test_masking();
      mask = 8'h7F;
      req_in = 8'h80; step();
      req_in = 8'h00; step(2);
      checks++;
      if (pending !== 8'h80) begin
         errors++;
         $display("FAIL mask_pending: got pending=%h, want 80", pending);
      end
      step(3);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mask_block: got valid=%b, want 0", out_valid);
      end
      mask = 8'hFF; step();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd7) begin
         errors++;
         $display("FAIL mask_release: got valid=%b id=%0d, want 1/7", out_valid, out_id);
      end
      out_ready = 1'b1; step();
      out_ready = 1'b0;
      checks++;
      if (pending !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mask_drain: got pending=%h valid=%b, want 00/0", pending, out_valid);
      end
   endtask

   task automatic test_overrun_clear();
      req_in = 8'h08; step();
      req_in = 8'h00; step();
      req_in = 8'h08; step();
      req_in = 8'h00; step(4);
      checks++;
      if (overrun !== 8'h08 || pending !== 8'h08 || out_id !== 3'd3 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: got overrun=%h pending=%h valid=%b id=%0d, want 08/08/1/3",
                  overrun, pending, out_valid, out_id);
      end
      // Bit 2 rise lands in the same cycle as clr_all and must be dropped.
      req_in = 8'h04; step();
      req_in = 8'h00; step();
      clr_all = 1'b1; step();
      clr_all = 1'b0;
      checks++;
      if (pending !== 8'h00 || overrun !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_all: got pending=%h overrun=%h valid=%b, want 00/00/0", pending, overrun, out_valid);
      end
      step(3);
      checks++;
      if (pending !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_drop: got pending=%h valid=%b, want 00/0", pending, out_valid);
      end
   endtask

   task automatic test_reset_mid_offer();
      req_in = 8'h20; step();
      req_in = 8'h00; step(3);
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd5) begin
         errors++;
         $display("FAIL pre_reset_offer: got valid=%b id=%0d, want 1/5", out_valid, out_id);
      end
      req_in = 8'h10;                  // held high through reset
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_id, pending, overrun} !== 20'd0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b id=%0d pending=%h overrun=%h, want all 0",
                  out_valid, out_id, pending, overrun);
      end
      step(2);
      rst_n = 1'b1;
      step(3);
      checks++;
      if (pending !== 8'h10) begin
         errors++;
         $display("FAIL held_line_event: got pending=%h, want 10", pending);
      end
      out_ready = 1'b1; step(4);
      checks++;
      if (pending !== 8'h00 || overrun !== 8'h00) begin
         errors++;
         $display("FAIL held_line_once: got pending=%h overrun=%h, want 00/00", pending, overrun);
      end
      out_ready = 1'b0; req_in = 8'h00;
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_priority_hold();
      test_offer_stability();
      test_masking();
      test_overrun_clear();
      test_reset_mid_offer();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
